// File: rtl/dpi_pmem_read_slave_pkg.sv
// Shared state/response types, access legality rule and the pmem read model for the read slave.
package pmem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only naturally aligned 1, 2 or 4 byte accesses reach memory.
    function automatic logic len_legal(input logic [31:0] len, input logic [31:0] addr);
        logic ok;
        case (len)
            32'd1:   ok = 1'b1;
            32'd2:   ok = (addr[0] == 1'b0);
            32'd4:   ok = (addr[1:0] == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Stand-in memory: every aligned word holds a fixed hash of its address.
    int unsigned pmem_read_calls;

    function automatic int pmem_read_dpi(input int en, input int addr, input int len);
        int word_addr;
        pmem_read_calls = pmem_read_calls + 1;
        if (en == 0 || len == 0) begin
            return 0;
        end
        word_addr = addr & 32'hFFFF_FFFC;
        return (word_addr * 32'h0001_0003) ^ 32'hC0DE_F00D;
    endfunction

endpackage

// File: rtl/dpi_pmem_read_slave_if.sv
// Read request/response channel between a memory requester (master) and the pmem read slave.
interface dpi_pmem_read_slave_if;

    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [31:0] ar_len;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    modport master (
        output ar_valid,
        output ar_addr,
        output ar_len,
        output r_ready,
        input  ar_ready,
        input  r_valid,
        input  r_data,
        input  r_resp
    );

    modport slave (
        input  ar_valid,
        input  ar_addr,
        input  ar_len,
        input  r_ready,
        output ar_ready,
        output r_valid,
        output r_data,
        output r_resp
    );

endinterface

// File: rtl/dpi_pmem_read_slave_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) feeding the random extra read latency.
// Only built when DPI_PMEM_READ_RAND_LAT_EN is defined.
`ifdef DPI_PMEM_READ_RAND_LAT_EN
module lfsr16 (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] state_q;
    logic        feedback;

    assign feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= seed;
        end else begin
            state_q <= {state_q[14:0], feedback};
        end
    end

    assign q = state_q;

endmodule
`endif

// File: rtl/dpi_pmem_read_slave.sv
// Valid/ready read responder in front of the pmem model: one request, programmable wait, held response.
// DPI_PMEM_READ_RAND_LAT_EN adds 0..3 pseudo-random extra wait cycles per request.
module dpi_pmem_read_slave
    import pmem_rd_pkg::*;
#(
    parameter int unsigned LATENCY   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic                  clock,
    input logic                  reset,
    dpi_pmem_read_slave_if.slave bus
);

`ifdef DPI_PMEM_READ_RAND_LAT_EN
    localparam int unsigned CntRange = LATENCY + 4;
`else
    localparam int unsigned CntRange = LATENCY + 1;
`endif
    localparam int unsigned CntW = ($clog2(CntRange) > 1) ? $clog2(CntRange) : 1;

    state_e          state_q;
    logic            ar_ready_q;
    logic            r_valid_q;
    logic [31:0]     r_data_q;
    logic [1:0]      r_resp_q;
    logic [31:0]     addr_q;
    logic [31:0]     len_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_load;
    logic            ar_hs;
    logic            rd_now;
    logic [31:0]     rd_addr;
    logic [31:0]     rd_len;

`ifdef DPI_PMEM_READ_RAND_LAT_EN
    logic [15:0] lfsr_val;
    logic        unused_lfsr;

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_val)
    );

    assign unused_lfsr = ^lfsr_val[15:2];
    assign cnt_load    = CntW'(LATENCY) + CntW'(lfsr_val[1:0]);
`else
    assign cnt_load = CntW'(LATENCY);
`endif

    assign ar_hs = (state_q == IDLE) && ar_ready_q && bus.ar_valid;

    // Zero wait reads at accept time; otherwise the read lands on the last WAIT cycle, so
    // r_valid is seen exactly 1 + wait cycles after the request handshake.
    assign rd_now  = (ar_hs && (cnt_load == '0)) ||
                     ((state_q == WAIT) && (cnt_q <= CntW'(1)));
    assign rd_addr = (state_q == IDLE) ? bus.ar_addr : addr_q;
    assign rd_len  = (state_q == IDLE) ? bus.ar_len  : len_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= 32'd0;
            r_resp_q   <= RESP_OKAY;
            addr_q     <= 32'd0;
            len_q      <= 32'd0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (ar_hs) begin
                        addr_q     <= bus.ar_addr;
                        len_q      <= bus.ar_len;
                        cnt_q      <= cnt_load;
                        ar_ready_q <= 1'b0;
                        state_q    <= rd_now ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (rd_now) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (bus.r_ready) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    ar_ready_q <= 1'b0;
                    r_valid_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase

            // The model is touched only here, once per legal accepted request.
            if (rd_now) begin
                r_valid_q <= 1'b1;
                if (len_legal(rd_len, rd_addr)) begin
                    r_data_q <= 32'(pmem_read_dpi(1, int'(rd_addr), int'(rd_len)));
                    r_resp_q <= RESP_OKAY;
                end else begin
                    r_data_q <= 32'd0;
                    r_resp_q <= RESP_SLVERR;
                end
            end
        end
    end

    assign bus.ar_ready = ar_ready_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_resp   = r_resp_q;

endmodule

// File: tb/tb_dpi_pmem_read_slave.sv
// Randomized bench for dpi_pmem_read_slave: two instances (LATENCY 0 and 1) against a memory/latency model.
module tb_dpi_pmem_read_slave;
    import pmem_rd_pkg::*;

`ifdef DPI_PMEM_READ_RAND_LAT_EN
    localparam int NumRand = 1000;
`else
    localparam int NumRand = 40;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [3:0] lat_seen = 4'b0000;

    dpi_pmem_read_slave_if bus0 ();
    dpi_pmem_read_slave_if bus1 ();

    dpi_pmem_read_slave #(.LATENCY(0)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
    dpi_pmem_read_slave #(.LATENCY(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory contents: aligned word at W holds (W * 0x10003) ^ 0xC0DEF00D.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return ((w << 16) + (w << 1) + w) ^ 32'hC0DE_F00D;
    endfunction

    function automatic bit is_legal(input logic [31:0] len, input logic [31:0] a);
        return (len == 1) || (len == 2 && a % 2 == 0) || (len == 4 && a % 4 == 0);
    endfunction

    task automatic set_ar(input int sel, input logic v, input logic [31:0] a, input logic [31:0] l);
        if (sel == 0) begin
            bus0.ar_valid = v; bus0.ar_addr = a; bus0.ar_len = l;
        end else begin
            bus1.ar_valid = v; bus1.ar_addr = a; bus1.ar_len = l;
        end
    endtask

    task automatic set_rready(input int sel, input logic v);
        if (sel == 0) bus0.r_ready = v;
        else          bus1.r_ready = v;
    endtask

    function automatic logic get_ar_ready(input int sel);
        return (sel == 0) ? bus0.ar_ready : bus1.ar_ready;
    endfunction

    function automatic logic get_r_valid(input int sel);
        return (sel == 0) ? bus0.r_valid : bus1.r_valid;
    endfunction

    function automatic logic [31:0] get_r_data(input int sel);
        return (sel == 0) ? bus0.r_data : bus1.r_data;
    endfunction

    function automatic logic [1:0] get_r_resp(input int sel);
        return (sel == 0) ? bus0.r_resp : bus1.r_resp;
    endfunction

    // One full transaction; lat is cycles from request handshake edge to the edge that sees r_valid.
    task automatic do_read(input int sel, input logic [31:0] addr, input logic [31:0] len,
                           input int stall, output int lat);
        int unsigned calls0;
        int          cyc;
        int          nom;
        logic        ok;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        nom      = (sel == 0) ? 0 : 1;
        ok       = is_legal(len, addr);
        exp_data = ok ? mem_word(addr) : 32'd0;
        exp_resp = ok ? 2'b00 : 2'b10;
        lat      = -1;
        set_ar(sel, 1'b1, addr, len);
        cyc = 0;
        while (!get_ar_ready(sel) && cyc < 16) begin
            tick();
            cyc++;
        end
        if (!get_ar_ready(sel)) begin
            check_eq("ar_ready_wait", get_ar_ready(sel), 1);
            set_ar(sel, 1'b0, 32'd0, 32'd0);
            return;
        end
        calls0 = pmem_read_calls;
        tick();
        set_ar(sel, 1'b0, $urandom, $urandom);
        cyc = 0;
        while (!get_r_valid(sel) && cyc < 16) begin
            check_eq("ar_ready_busy", get_ar_ready(sel), 0);
            tick();
            cyc++;
        end
        if (!get_r_valid(sel)) begin
            check_eq("r_valid_wait", get_r_valid(sel), 1);
            return;
        end
        lat = cyc + 1;
`ifdef DPI_PMEM_READ_RAND_LAT_EN
        begin
            int lo;
            int hi;
            int clamped;
            lo = nom + 1;
            hi = nom + 4;
            clamped = (lat < lo) ? lo : ((lat > hi) ? hi : lat);
            check_eq("latency_range", lat, clamped);
            if (lat >= lo && lat <= hi) lat_seen[lat-lo] = 1'b1;
        end
`else
        check_eq("latency", lat, nom + 1);
`endif
        check_eq("r_data", get_r_data(sel), exp_data);
        check_eq("r_resp", {30'd0, get_r_resp(sel)}, {30'd0, exp_resp});
        check_eq("dpi_calls", pmem_read_calls - calls0, ok ? 1 : 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("stall_r_valid", get_r_valid(sel), 1);
            check_eq("stall_r_data", get_r_data(sel), exp_data);
            check_eq("stall_r_resp", {30'd0, get_r_resp(sel)}, {30'd0, exp_resp});
            check_eq("stall_ar_ready", get_ar_ready(sel), 0);
        end
        set_rready(sel, 1'b1);
        tick();
        set_rready(sel, 1'b0);
        check_eq("r_valid_drop", get_r_valid(sel), 0);
        check_eq("ar_ready_back", get_ar_ready(sel), 1);
        check_eq("dpi_calls_final", pmem_read_calls - calls0, ok ? 1 : 0);
    endtask

    initial begin
        int          lat;
        int unsigned calls0;
        logic [31:0] len_tab [6];
        logic [31:0] addr;
        logic [31:0] len;
        len_tab = '{32'd1, 32'd2, 32'd4, 32'd4, 32'd3, 32'd8};

        set_ar(0, 1'b0, 32'd0, 32'd0);
        set_ar(1, 1'b0, 32'd0, 32'd0);
        set_rready(0, 1'b0);
        set_rready(1, 1'b0);
        reset = 1'b0;
        repeat (3) tick();
        check_eq("rst_ar_ready1", bus1.ar_ready, 0);
        check_eq("rst_ar_ready0", bus0.ar_ready, 0);
        check_eq("rst_r_valid", bus1.r_valid, 0);
        check_eq("rst_r_data", bus1.r_data, 32'd0);
        check_eq("rst_r_resp", {30'd0, bus1.r_resp}, {30'd0, RESP_OKAY});
        reset = 1'b1;
        tick();
        check_eq("post_rst_ar_ready1", bus1.ar_ready, 1);
        check_eq("post_rst_ar_ready0", bus0.ar_ready, 1);

        // Directed: aligned word, stalled response, illegal accesses.
        do_read(1, 32'h8000_0000, 32'd4, 0, lat);
        do_read(1, 32'h8000_0010, 32'd4, 5, lat);
        do_read(1, 32'h8000_0002, 32'd4, 0, lat);
        do_read(1, 32'h8000_0000, 32'd3, 0, lat);
        do_read(0, 32'h8000_0001, 32'd2, 1, lat);
        do_read(0, 32'h8000_0003, 32'd1, 0, lat);

        // Back-to-back with ar_valid and r_ready held high on the zero-latency instance.
        begin
            logic [31:0] exp_q [$];
            logic [31:0] a;
            logic        hs;
            int          last_acc;
            int          n_acc;
            int          n_rsp;
            set_rready(0, 1'b1);
            a = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            set_ar(0, 1'b1, a, 32'd4);
            last_acc = -1;
            n_acc    = 0;
            n_rsp    = 0;
            for (int c = 0; c < 200 && n_rsp < 12; c++) begin
                hs = bus0.ar_valid && bus0.ar_ready;
                if (bus0.r_valid) begin
                    check_eq("b2b_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check_eq("b2b_data", bus0.r_data, exp_q.pop_front());
                    check_eq("b2b_resp", {30'd0, bus0.r_resp}, 32'd0);
                    n_rsp++;
                end
                tick();
                if (hs) begin
                    exp_q.push_back(mem_word(a));
                    if (last_acc >= 0) begin
`ifdef DPI_PMEM_READ_RAND_LAT_EN
                        int sp;
                        sp = c - last_acc;
                        check_eq("b2b_spacing", sp, (sp < 2) ? 2 : ((sp > 5) ? 5 : sp));
`else
                        check_eq("b2b_spacing", c - last_acc, 2);
`endif
                    end
                    last_acc = c;
                    n_acc++;
                    a = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
                    set_ar(0, n_acc < 12, a, 32'd4);
                end
            end
            check_eq("b2b_count", n_rsp, 12);
            check_eq("b2b_leftover", exp_q.size(), 0);
            set_ar(0, 1'b0, 32'd0, 32'd0);
            set_rready(0, 1'b0);
            tick();
        end

        // Reset while the LATENCY=1 instance is waiting: request dropped, no read.
        set_ar(1, 1'b1, 32'h8000_0040, 32'd4);
        for (int i = 0; i < 16 && !bus1.ar_ready; i++) tick();
        check_eq("rstw_ready_before", bus1.ar_ready, 1);
        calls0 = pmem_read_calls;
        tick();
        set_ar(1, 1'b0, 32'd0, 32'd0);
        check_eq("rstw_in_wait", bus1.ar_ready, 0);
        reset = 1'b0;
        tick();
        check_eq("rstw_r_valid", bus1.r_valid, 0);
        check_eq("rstw_ar_ready", bus1.ar_ready, 0);
        check_eq("rstw_calls", pmem_read_calls - calls0, 0);
        reset = 1'b1;
        tick();
        check_eq("rstw_ready_after", bus1.ar_ready, 1);
        repeat (4) tick();
        check_eq("rstw_r_valid_late", bus1.r_valid, 0);
        check_eq("rstw_calls_late", pmem_read_calls - calls0, 0);

        // Random mix of sizes, alignments, instances and stalls.
        for (int i = 0; i < NumRand; i++) begin
            int sel;
            sel  = int'($urandom_range(0, 1));
            len  = len_tab[$urandom_range(0, 5)];
            addr = 32'h8000_0000 + $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC;
            do_read(sel, addr, len, int'($urandom_range(0, 3)), lat);
        end
`ifdef DPI_PMEM_READ_RAND_LAT_EN
        check_eq("lat_all_seen", {28'd0, lat_seen}, 32'hF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
